// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter handing the shared tagged system bus to one of NUM_CLIENTS masters
// for a whole transaction: request beats, then a fixed-length response burst for reads.
module bus_arbiter_rr #(
    parameter int NUM_CLIENTS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 13,
    parameter int RESP_BEATS  = 8,
    parameter int WRITE_BIT   = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            cl_reqcyc,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_req,
    input  logic [NUM_CLIENTS*TAG_WIDTH-1:0]  cl_reqtag,
    output logic [NUM_CLIENTS-1:0]            cl_reqack,
    output logic [NUM_CLIENTS-1:0]            cl_respcyc,
    output logic [DATA_WIDTH-1:0]             cl_resp,
    output logic [TAG_WIDTH-1:0]              cl_resptag,
    input  logic [NUM_CLIENTS-1:0]            cl_respack,
    output logic                              bus_reqcyc,
    output logic [DATA_WIDTH-1:0]             bus_req,
    output logic [TAG_WIDTH-1:0]              bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [DATA_WIDTH-1:0]             bus_resp,
    input  logic [TAG_WIDTH-1:0]              bus_resptag,
    output logic                              bus_respack,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic                              stray_resp
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(RESP_BEATS + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             beat_seen_reg, beat_seen_next;
    logic             is_write_reg, is_write_next;
    logic             stray_reg, stray_next;

    logic [DATA_WIDTH-1:0] req_data [NUM_CLIENTS];
    logic [TAG_WIDTH-1:0]  req_tag  [NUM_CLIENTS];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [IDX_W-1:0]      owner_inc;
    logic                  owner_req;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_CLIENTS);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slice
            assign req_data[gi] = cl_req[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_tag[gi]  = cl_reqtag[gi*TAG_WIDTH +: TAG_WIDTH];
        end
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_grant
            assign grant[gi] = (state_reg != IDLE) && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (cl_reqcyc[wrap_idx(int'(rr_ptr_reg) + k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(int'(rr_ptr_reg) + k);
            end
        end
    end

    assign owner_inc  = wrap_idx(int'(owner_reg) + 1);
    assign owner_req  = cl_reqcyc[owner_reg];
    assign bus_req    = req_data[owner_reg];
    assign bus_reqtag = req_tag[owner_reg];
    assign cl_resp    = bus_resp;
    assign cl_resptag = bus_resptag;
    assign stray_resp = stray_reg;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        cnt_next       = cnt_reg;
        beat_seen_next = beat_seen_reg;
        is_write_next  = is_write_reg;
        stray_next     = bus_respcyc && (state_reg != RESP);
        bus_reqcyc     = 1'b0;
        bus_respack    = 1'b0;
        cl_reqack      = '0;
        cl_respcyc     = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next     = pick_idx;
                    beat_seen_next = 1'b0;
                    is_write_next  = 1'b0;
                    state_next     = REQ;
                end
            end
            REQ: begin
                bus_reqcyc           = owner_req;
                cl_reqack[owner_reg] = bus_reqack;
                // The first accepted beat decides read versus write for the whole transaction.
                if (owner_req && bus_reqack && !beat_seen_reg) begin
                    beat_seen_next = 1'b1;
                    is_write_next  = req_tag[owner_reg][WRITE_BIT];
                end
                if (!owner_req) begin
                    if (beat_seen_reg && !is_write_reg) begin
                        state_next = RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_inc;
                    end
                end
            end
            RESP: begin
                cl_respcyc[owner_reg] = bus_respcyc;
                bus_respack           = cl_respack[owner_reg];
                if (bus_respcyc && bus_respack) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(RESP_BEATS - 1)) begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            beat_seen_reg <= 1'b0;
            is_write_reg  <= 1'b0;
            stray_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            cnt_reg       <= cnt_next;
            beat_seen_reg <= beat_seen_next;
            is_write_reg  <= is_write_next;
            stray_reg     <= stray_next;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a transaction-level round-robin model predicts
// grant order, forwarded request beats and response routing; a monitor compares them.
module tb_bus_arbiter_rr;
    localparam int N = 4, DW = 64, TW = 13, RB = 8, WB = 12, MAXB = 8;
    localparam int K_READ = 0, K_WRITE = 1, K_ABANDON = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cl_reqcyc;
    logic [N*DW-1:0] cl_req;
    logic [N*TW-1:0] cl_reqtag;
    logic [N-1:0]    cl_reqack;
    logic [N-1:0]    cl_respcyc;
    logic [DW-1:0]   cl_resp;
    logic [TW-1:0]   cl_resptag;
    logic [N-1:0]    cl_respack;
    logic            bus_reqcyc;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack;
    logic            bus_respcyc;
    logic [DW-1:0]   bus_resp;
    logic [TW-1:0]   bus_resptag;
    logic            bus_respack;
    logic [N-1:0]    grant;
    logic            stray_resp;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_CLIENTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .RESP_BEATS(RB), .WRITE_BIT(WB)
    ) dut (
        .clk(clk), .reset(reset),
        .cl_reqcyc(cl_reqcyc), .cl_req(cl_req), .cl_reqtag(cl_reqtag), .cl_reqack(cl_reqack),
        .cl_respcyc(cl_respcyc), .cl_resp(cl_resp), .cl_resptag(cl_resptag), .cl_respack(cl_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .grant(grant), .stray_resp(stray_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT produced an event with nothing expected at %0t", name, $time);
    endtask

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Scoreboard queues filled by the stimulus side
    typedef struct { int client; logic [DW-1:0] data; logic [TW-1:0] tag; } resp_t;
    int               exp_grant_q[$];
    logic [DW+TW-1:0] exp_beat_q[$];
    resp_t            exp_resp_q[$];

    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        int o;
        logic [DW+TW-1:0] eb;
        resp_t er;
        if (grant != '0 && prev_grant == '0) begin
            if (exp_grant_q.size() == 0) report_unexpected("grant");
            else begin
                o = exp_grant_q.pop_front();
                check("grant_owner", grant, onehot(o));
            end
        end
        if (bus_reqcyc && bus_reqack) begin
            if (exp_beat_q.size() == 0) report_unexpected("req_beat");
            else begin
                eb = exp_beat_q.pop_front();
                check("req_data", bus_req, eb[DW+TW-1:TW]);
                check("req_tag", bus_reqtag, eb[TW-1:0]);
            end
        end
        if (bus_respcyc && bus_respack) begin
            if (exp_resp_q.size() == 0) report_unexpected("resp_beat");
            else begin
                er = exp_resp_q.pop_front();
                check("resp_route", cl_respcyc, onehot(er.client));
                check("resp_data", cl_resp, er.data);
                check("resp_tag", cl_resptag, er.tag);
            end
        end
        prev_grant <= grant;
    end

    // Per-client transaction descriptors and the round-robin reference state
    logic [DW-1:0] t_data [N][MAXB];
    logic [TW-1:0] t_tag  [N];
    int            t_kind [N];
    int            t_beats[N];
    int            order_q[$];
    int            model_ptr = 0;
    int            ack_mode  = 0;
    int            stall_at  = -1;
    int            abort_at  = -1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_txn(input int c, input int kind, input int beats);
        t_kind[c]  = kind;
        t_beats[c] = beats;
        for (int b = 0; b < MAXB; b++) t_data[c][b] = {$urandom, $urandom};
        t_tag[c]     = TW'($urandom);
        t_tag[c][WB] = (kind == K_WRITE);
    endtask

    // With every requester held until served, service order is a pure walk from the pointer.
    task automatic plan_round(input logic [N-1:0] mask);
        logic [N-1:0] left;
        int c;
        left = mask;
        order_q.delete();
        while (left != '0) begin
            for (int k = 0; k < N; k++) begin
                c = (model_ptr + k) % N;
                if (left[c]) begin
                    order_q.push_back(c);
                    exp_grant_q.push_back(c);
                    left[c]   = 1'b0;
                    model_ptr = (c + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic reset_mid(input int o);
        bus_respcyc = 1'b1;
        cl_respack  = '0;
        reset       = 1'b1;
        @(negedge clk);
        check("pre_reset_route", cl_respcyc, onehot(o));
        tick();
        reset      = 1'b0;
        cl_respack = '1;
        model_ptr  = 0;
        @(negedge clk);
        check("rst_grant", grant, '0);
        check("rst_respcyc", cl_respcyc, '0);
        check("rst_respack", bus_respack, 1'b0);
        check("rst_reqcyc", bus_reqcyc, 1'b0);
        check("rst_reqack", cl_reqack, '0);
        tick();
        bus_respcyc = 1'b0;
        cl_respack  = '0;
        @(negedge clk);
        check("stray_pulse", stray_resp, 1'b1);
        tick();
        @(negedge clk);
        check("stray_clear", stray_resp, 1'b0);
        tick();
    endtask

    task automatic serve(input int o);
        int b, guard, got, stall;
        logic pushed, ack_o;
        b = 0; guard = 0; pushed = 1'b0;
        bus_reqack = 1'b0;
        if (t_kind[o] == K_ABANDON) begin
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                check("abandon_hold", bus_reqcyc, 1'b1);
                check("abandon_ack", cl_reqack, '0);
                tick();
            end
            cl_reqcyc[o] = 1'b0;
            @(negedge clk);
            check("abandon_drop", bus_reqcyc, 1'b0);
            tick();
            return;
        end
        while (b < t_beats[o]) begin
            cl_req[o*DW +: DW] = t_data[o][b];
            if (!pushed) begin
                exp_beat_q.push_back({t_data[o][b], t_tag[o]});
                pushed = 1'b1;
            end
            if (ack_mode == 1) bus_reqack = ~bus_reqack;
            else bus_reqack = ($urandom % 2) == 1;
            if (guard > 30) bus_reqack = 1'b1;
            @(negedge clk);
            check("req_pass", bus_reqcyc, 1'b1);
            check("reqack_route", cl_reqack, onehot(o) & {N{bus_reqack}});
            if (bus_reqack) begin
                b++;
                pushed = 1'b0;
            end
            guard++;
            tick();
        end
        cl_reqcyc[o] = 1'b0;
        bus_reqack   = ($urandom % 2) == 1;
        @(negedge clk);
        check("req_drop", bus_reqcyc, 1'b0);
        tick();
        bus_reqack = 1'b0;
        if (t_kind[o] == K_WRITE) return;

        got = 0; stall = 0; guard = 0;
        while (got < RB) begin
            if (got == abort_at) begin
                reset_mid(o);
                return;
            end
            bus_resp    = {$urandom, $urandom};
            bus_resptag = TW'($urandom);
            bus_respcyc = ($urandom % 4) != 0;
            cl_respack  = N'($urandom);
            ack_o       = ($urandom % 4) != 0;
            if (guard > 60) begin
                bus_respcyc = 1'b1;
                ack_o       = 1'b1;
            end
            if (got == stall_at && stall < 3) begin
                bus_respcyc = 1'b1;
                ack_o       = 1'b0;
                stall++;
            end
            cl_respack[o] = ack_o;
            if (bus_respcyc && ack_o) exp_resp_q.push_back('{o, bus_resp, bus_resptag});
            @(negedge clk);
            check("respack_pass", bus_respack, ack_o);
            check("respcyc_route", cl_respcyc, onehot(o) & {N{bus_respcyc}});
            check("resp_no_req", bus_reqcyc, 1'b0);
            check("resp_no_reqack", cl_reqack, '0);
            check("grant_hold", grant, onehot(o));
            if (bus_respcyc && ack_o) got++;
            guard++;
            tick();
        end
        bus_respcyc = 1'b0;
        cl_respack  = '0;
    endtask

    task automatic run_round(input logic [N-1:0] mask);
        int o;
        plan_round(mask);
        for (int c = 0; c < N; c++) begin
            if (mask[c]) begin
                cl_req[c*DW +: DW]    = t_data[c][0];
                cl_reqtag[c*TW +: TW] = t_tag[c];
            end
        end
        cl_reqcyc = mask;
        @(negedge clk);
        check("arb_wait_grant", grant, '0);
        check("arb_wait_reqcyc", bus_reqcyc, 1'b0);
        tick();
        while (order_q.size() > 0) begin
            o = order_q.pop_front();
            serve(o);
            @(negedge clk);
            check("idle_gap", grant, '0);
            tick();
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        int r;
        reset = 1'b1;
        cl_reqcyc = '0; cl_req = '0; cl_reqtag = '0; cl_respack = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_grant", grant, '0);
        check("reset_bus_reqcyc", bus_reqcyc, 1'b0);
        check("reset_cl_reqack", cl_reqack, '0);
        check("reset_cl_respcyc", cl_respcyc, '0);
        check("reset_bus_respack", bus_respack, 1'b0);
        check("reset_stray", stray_resp, 1'b0);
        reset = 1'b0;
        tick();

        make_txn(0, K_READ, 1);
        t_data[0][0] = 64'h1000;
        t_tag[0]     = '0;
        run_round(4'b0001);

        repeat (3) begin
            make_txn(0, K_READ, 2);
            make_txn(1, K_READ, 2);
            run_round(4'b0011);
        end

        make_txn(1, K_WRITE, 8);
        ack_mode = 1;
        run_round(4'b0010);
        ack_mode = 0;

        make_txn(0, K_READ, 1);
        stall_at = 4;
        run_round(4'b0001);
        stall_at = -1;

        make_txn(1, K_READ, 1);
        run_round(4'b0010);
        make_txn(2, K_READ, 1);
        abort_at = 4;
        run_round(4'b0100);
        abort_at = -1;
        make_txn(1, K_READ, 1);
        make_txn(3, K_WRITE, 2);
        run_round(4'b1010);

        make_txn(2, K_READ, 1);
        run_round(4'b0100);
        make_txn(1, K_READ, 2);
        make_txn(3, K_READ, 2);
        run_round(4'b1010);

        repeat (40) begin
            mask = N'($urandom_range(15, 1));
            for (int c = 0; c < N; c++) begin
                r = $urandom_range(9, 0);
                make_txn(c, (r < 6) ? K_READ : (r < 9) ? K_WRITE : K_ABANDON, $urandom_range(4, 1));
            end
            run_round(mask);
        end

        repeat (3) tick();
        check("grant_q_drained", exp_grant_q.size(), 0);
        check("beat_q_drained", exp_beat_q.size(), 0);
        check("resp_q_drained", exp_resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-client, round-robin arbiter between the core's bus masters (fetcher, data memory, future prefetch/DMA clients) and the single shared tagged system bus.
- Generalises the fixed two-port instruction/data arbiter in three ways: configurable client count, configurable response burst length, and write transactions that expect no response.
- Owns the bus for a whole transaction (request beats plus response burst) and routes response beats only to the owning client.

Parameters:
- NUM_CLIENTS, 2, number of requesting masters (≥2); client 0 has highest priority out of reset.
- DATA_WIDTH, 64, bus request/response data width.
- TAG_WIDTH, 13, bus tag width.
- RESP_BEATS, 8, response beats per read transaction.
- WRITE_BIT, 12, tag bit index that marks a write (1 = write, no response expected).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cl_reqcyc  input  NUM_CLIENTS  per-client request valid.
- cl_req  input  NUM_CLIENTS*DATA_WIDTH  per-client request data; client i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- cl_reqtag  input  NUM_CLIENTS*TAG_WIDTH  per-client request tag, sliced as cl_req.
- cl_reqack  output  NUM_CLIENTS  per-client request-beat accept.
- cl_respcyc  output  NUM_CLIENTS  per-client response valid.
- cl_resp  output  DATA_WIDTH  response data, broadcast to all clients.
- cl_resptag  output  TAG_WIDTH  response tag, broadcast to all clients.
- cl_respack  input  NUM_CLIENTS  per-client response accept.
- bus_reqcyc, bus_req, bus_reqtag  output  1/DATA_WIDTH/TAG_WIDTH  system bus request.
- bus_reqack  input  1  bus request-beat accept.
- bus_respcyc, bus_resp, bus_resptag  input  1/DATA_WIDTH/TAG_WIDTH  system bus response.
- bus_respack  output  1  response accept to bus.
- grant  output  NUM_CLIENTS  one-hot current owner; 0 when IDLE.
- stray_resp  output  1  one-cycle pulse when a response beat arrives with no reading owner.

Behaviour:
- Reset is synchronous, active-high, on clk.
  - At the reset edge: state←IDLE, rr_ptr←0, beat counter←0, stray_resp←0.
  - All strobe outputs are decoded from state, so they read 0 from that edge on: cl_reqack, cl_respcyc, bus_reqcyc, bus_respack, grant.
  - Reset mid-transaction abandons the transaction without completing it.
- State machine has three states: IDLE, REQ, RESP.
- IDLE:
  - If any cl_reqcyc is set, select the first requester scanning rr_ptr, rr_ptr+1, … modulo NUM_CLIENTS.
  - Register it as owner; next state is REQ.
  - Arbitration latency is exactly 1 cycle: bus_reqcyc first rises the cycle after cl_reqcyc is sampled.
- REQ (owner o):
  - Combinational pass-through: bus_reqcyc=cl_reqcyc[o], bus_req/bus_reqtag = slice o, cl_reqack[o]=bus_reqack; all other cl_reqack are 0.
  - An accepted beat is bus_reqcyc&bus_reqack. The tag of the first accepted beat is latched and defines the transaction type.
  - A cycle with cl_reqcyc[o]=0 after ≥1 accepted beat ends the request phase:
    - write (latched tag[WRITE_BIT]=1) → IDLE, rr_ptr←(o+1) mod N;
    - read → RESP with counter←0.
  - A cycle with cl_reqcyc[o]=0 before any accepted beat: abandon → IDLE, rr_ptr←(o+1) mod N.
- RESP (owner o):
  - cl_respcyc[o]=bus_respcyc; all other cl_respcyc are 0.
  - bus_respack=cl_respack[o].
  - bus_reqcyc=0 throughout RESP.
  - Counter increments on each bus_respcyc&bus_respack.
  - On the beat making the counter equal RESP_BEATS → IDLE, rr_ptr←(o+1) mod N.
  - A stalled beat (respcyc high, respack low) is not counted.
- Stray responses: bus_respcyc high in IDLE or REQ is not forwarded and bus_respack=0. stray_resp pulses high on the next cycle, once per cycle the condition holds.
- cl_resp and cl_resptag always equal bus_resp and bus_resptag (broadcast); only cl_respcyc qualifies them.
- Back-to-back transactions: IDLE is always visited between transactions, so there is a minimum of 1 idle bus cycle between them.
- Fairness: a continuously requesting client waits at most NUM_CLIENTS-1 transactions.
- Counter width is $clog2(RESP_BEATS+1).
- All slice indexing uses the registered owner index; grant is the one-hot decode of that owner, gated by state≠IDLE.

Test Plan:
- Reset, then client 0 issues a read with tag 0x000 and addr 0x1000 → bus_reqcyc=1 one cycle later with bus_req=0x1000. After the ack and reqcyc drop, 8 response beats are routed only to cl_respcyc[0], then grant=0.
- N=2, both clients request continuously with reads → grants alternate 0,1,0,1; one idle cycle between transactions; no client is granted twice in a row.
- Client 1 issues a write: tag bit12=1, 8 request beats, bus_reqack stalling every other beat → 8 accepted beats, then IDLE with no RESP state and bus_respack never asserted.
- Read in RESP, client stalls: cl_respack low for 3 cycles on beat 4 → bus_respack low for those cycles, counter holds at 4, completion still occurs after exactly 8 acked beats.
- bus_respcyc asserted while in IDLE → no cl_respcyc, bus_respack=0, stray_resp pulses 1 cycle. Then reset asserted during RESP beat 5 → all strobes 0, rr_ptr=0, next requester from 0 wins.
- NUM_CLIENTS=4, RESP_BEATS=4, clients 1 and 3 request after client 2 finishes → client 3 is granted first (rr_ptr=3), then client 1.
